// File: rtl/addsub_pkg.sv
// addsub_pkg
//   Shared definitions for the digit-serial adder/subtractor:
//   - state_e  : FSM state encoding (IDLE, RUN, DONE), 2 bits
//   - MODE_ADD / MODE_SUB : values of the mode input
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : addsub_pkg

// File: rtl/addsub_serial_digit_adder.sv
// digit_adder
//   Combinational DIGIT-bit ripple adder slice used by addsub_serial.
//   Ports:
//     x, y   : DIGIT-bit addends
//     ci     : carry in
//     s      : DIGIT-bit sum
//     co     : carry out of bit DIGIT-1
//     c_msb  : carry into bit DIGIT-1 (needed for signed overflow)
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] sum_ext;

    always_comb begin
        sum_ext = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
        s       = sum_ext[DIGIT-1:0];
        co      = sum_ext[DIGIT];
        // The top sum bit is x^y^carry_in, so the carry into it can be recovered.
        c_msb   = sum_ext[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
    end

endmodule : digit_adder

// File: rtl/addsub_serial.sv
// addsub_serial
//   Multi-cycle WIDTH-bit adder/subtractor that processes DIGIT bits per
//   clock through one shared digit_adder. Start/done handshake.
//   Ports:
//     clk, rst     : clock (rising edge), synchronous active-high reset
//     start        : request, accepted in IDLE or DONE
//     mode         : 0 = a+b, 1 = a-b (latched with start)
//     a, b         : operands (latched with start)
//     busy         : high while the digits are being processed
//     done         : one-cycle pulse when result and flags are valid
//     result       : sum/difference modulo 2^WIDTH
//     cb           : carry-out (add) or borrow, a<b unsigned (sub)
//     ovf          : signed two's-complement overflow
//     zero         : result == 0
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cb,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
            $error("addsub_serial: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
        end
    endgenerate

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic               carry_q,  carry_d;
    logic               mode_q,   mode_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cb_q,     cb_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;

    logic [DIGIT-1:0]   dig_s;
    logic               dig_co;
    logic               dig_cmsb;
    logic [WIDTH-1:0]   result_shift;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        result_d = result_q;
        cb_d     = cb_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        // New digit enters at the MSB end; after STEPS shifts the first
        // (least significant) digit has arrived at bit 0.
        result_shift = (result_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                result_d = result_shift;
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                carry_d  = dig_co;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    // Subtract is a + ~b + 1, so its carry-out is the inverse of borrow.
                    cb_d    = (mode_q == MODE_SUB) ? ~dig_co : dig_co;
                    ovf_d   = dig_cmsb ^ dig_co;
                    zero_d  = (result_shift == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // start is only honoured when no operation is in flight.
        if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            a_d      = a;
            b_d      = (mode == MODE_SUB) ? ~b : b;
            carry_d  = mode;
            mode_d   = mode;
            result_d = '0;
            cb_d     = 1'b0;
            ovf_d    = 1'b0;
            zero_d   = 1'b0;
        end
    end

    // Control state and visible outputs: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Working datapath: always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        cnt_q   <= cnt_d;
        a_q     <= a_d;
        b_q     <= b_d;
        carry_q <= carry_d;
        mode_q  <= mode_d;
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cb     = cb_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule : addsub_serial

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;

    localparam int W       = 16;
    localparam int D       = 4;
    localparam int LATENCY = W / D + 1;
    localparam int TIMEOUT = 20;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cb;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cb, ovf, zero;
    logic [W-1:0] result;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cb     (cb),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    // Independent reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W:0]   wide;
        if (m == 1'b0) begin
            wide  = {1'b0, x} + {1'b0, y};
            e.res = wide[W-1:0];
            e.cb  = wide[W];
            e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
        end else begin
            e.res = x - y;
            e.cb  = (x < y);
            e.ovf = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Called #1 after an edge: presents a request, lets the next edge sample it,
    // and records the expected outcome. Returns #1 after that edge (cycle t+1).
    task automatic launch(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        mode  = m;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(m, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom();
        b     = $urandom();
        mode  = $urandom_range(0, 1);
    endtask

    // Observes cycles starting at t+1 until done, reporting which cycle done
    // appeared in (0 = never) and how many of the preceding cycles had busy high.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (done) begin
                cyc = k;
                return;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result, cb, ovf, zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h cb=%b ovf=%b zero=%b, want all 0",
                     busy, done, result, cb, ovf, zero);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors;
        logic         vm[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] va[5]  = '{16'd200, 16'd100, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [W-1:0] vb[5]  = '{16'd100, 16'd200, 16'h0001, 16'h0001, 16'h0001};
        exp_t         vx[5]  = '{{16'd100,  1'b0, 1'b0, 1'b0},
                                 {16'hFF9C, 1'b1, 1'b0, 1'b0},
                                 {16'h8000, 1'b0, 1'b1, 1'b0},
                                 {16'h7FFF, 1'b0, 1'b1, 1'b0},
                                 {16'h0000, 1'b1, 1'b0, 1'b1}};
        int   cyc, bc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            launch(vm[i], va[i], vb[i]);
            wait_done(cyc, bc);
            e = exp_q.pop_front();
            n_cmp++;
            if (e !== vx[i]) begin
                n_bad++;
                $display("FAIL vec%0d_model: model %h, table %h", i, e, vx[i]);
            end
            n_cmp++;
            if (cyc != LATENCY || bc != LATENCY - 1) begin
                n_bad++;
                $display("FAIL vec%0d_timing: done at cycle %0d busy %0d cycles, want %0d / %0d",
                         i, cyc, bc, LATENCY, LATENCY - 1);
            end
            n_cmp++;
            if ({result, cb, ovf, zero} !== vx[i]) begin
                n_bad++;
                $display("FAIL vec%0d_result: got res=%h cb=%b ovf=%b zero=%b, want res=%h cb=%b ovf=%b zero=%b",
                         i, result, cb, ovf, zero, vx[i].res, vx[i].cb, vx[i].ovf, vx[i].zero);
            end
            // done must be a single pulse, and outputs hold afterwards.
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || {result, cb, ovf, zero} !== vx[i]) begin
                n_bad++;
                $display("FAIL vec%0d_hold: got done=%b busy=%b res=%h, want done=0 busy=0 res=%h",
                         i, done, busy, result, vx[i].res);
            end
        end
    endtask

    task automatic test_random;
        int   cyc, bc;
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            launch($urandom_range(0, 1), $urandom(), $urandom());
            wait_done(cyc, bc);
            e = exp_q.pop_front();
            n_cmp++;
            if (cyc != LATENCY || {result, cb, ovf, zero} !== e) begin
                n_bad++;
                $display("FAIL random%0d: cyc=%0d res=%h cb=%b ovf=%b zero=%b, want cyc=%0d res=%h cb=%b ovf=%b zero=%b",
                         i, cyc, result, cb, ovf, zero, LATENCY, e.res, e.cb, e.ovf, e.zero);
            end
            if (i % 3 == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_start_while_busy;
        int   cyc, bc, pulses;
        exp_t e;
        launch(1'b1, 16'd1000, 16'd1);
        // Now in cycle t+1; re-pulse start with different operands at t+2.
        @(posedge clk);
        #1;
        a = 16'h1234; b = 16'h4321; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        for (int k = 3; k <= TIMEOUT; k++) begin
            if (done) begin cyc = k; break; end
            @(posedge clk);
            #1;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc != LATENCY || {result, cb, ovf, zero} !== e) begin
            n_bad++;
            $display("FAIL busy_start: cyc=%0d res=%h, want cyc=%0d res=%h", cyc, result, LATENCY, e.res);
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL busy_start_no_second_op: got %0d busy/done cycles, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int   cyc, bc;
        exp_t e;
        launch(1'b0, 16'h0F0F, 16'h1111);
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc != LATENCY || {result, cb, ovf, zero} !== e) begin
            n_bad++;
            $display("FAIL b2b_first: cyc=%0d res=%h, want cyc=%0d res=%h", cyc, result, LATENCY, e.res);
        end
        // Issue the next request in the DONE cycle itself.
        launch(1'b1, 16'h0003, 16'h0005);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== '0) begin
            n_bad++;
            $display("FAIL b2b_restart: got busy=%b done=%b res=%h, want busy=1 done=0 res=0000",
                     busy, done, result);
        end
        wait_done(cyc, bc);
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc != LATENCY || {result, cb, ovf, zero} !== e) begin
            n_bad++;
            $display("FAIL b2b_second: cyc=%0d res=%h cb=%b, want cyc=%0d res=%h cb=%b",
                     cyc, result, cb, LATENCY, e.res, e.cb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        launch(1'b0, 16'h1234, 16'h1111);
        @(posedge clk);
        #1;
        // Second RUN cycle.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_cmp++;
        if ({busy, done, result, cb, ovf, zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run: got busy=%b done=%b result=%h cb=%b ovf=%b zero=%b, want all 0",
                     busy, done, result, cb, ovf, zero);
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL reset_mid_run_done: got %0d done pulses, want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_addsub_serial

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle N-bit adder/subtractor that processes operands DIGIT bits per clock with a start/done handshake. It generalises the team's fixed 16-bit combinational subtractor: selectable add or subtract, configurable width and digit size, and carry/borrow, signed overflow and zero flags. It sits in the datapath wherever a narrow adder must be time-shared across a wide operand.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per RUN cycle; DIGIT == WIDTH gives single-cycle operation.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset. Synchronous and active-high.
- start  input  1  request. Sampled only in IDLE or DONE.
- mode  input  1  operation select: 0 = a+b, 1 = a-b. Latched with start.
- a  input  WIDTH  operand A, unsigned or two's complement. Latched with start.
- b  input  WIDTH  operand B. Latched with start.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse when the result is valid.
- result  output  WIDTH  sum or difference modulo 2^WIDTH.
- cb  output  1  add: carry-out. Sub: borrow, where 1 means a < b unsigned.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

## Operation
- STEPS = WIDTH/DIGIT.
- FSM states:
  - IDLE: start=1 → RUN.
  - RUN: stays for STEPS cycles, then → DONE.
  - DONE: start=1 → RUN, otherwise → IDLE.
- On an accepted start:
  - Latch a, and latch b as b for add or ~b for sub.
  - Set the internal carry to mode (carry-in 1 for subtract).
  - Clear the step counter.
  - Clear result, cb, ovf and zero.
- Each RUN cycle:
  - Add the low DIGIT bits of the A and B shift registers plus the carry.
  - Shift the sum digit into result from the MSB end, so after STEPS cycles the LSB digit sits at bit 0.
  - Shift both operand registers right by DIGIT.
  - Update the carry and increment the step counter.
- The final RUN cycle also captures:
  - carry into the MSB (c_in_msb) and carry out of the MSB (c_out), for the ovf calculation.
- On entry to DONE:
  - cb = c_out for add, ~c_out for sub.
  - ovf = c_in_msb ^ c_out.
  - zero = (final result == 0).
- Outputs result, cb, ovf and zero hold their values from DONE until the next accepted start.
- start while busy is ignored; there is no queueing.
- Reset (rst=1 at a clock edge):
  - Next state is IDLE, regardless of start.
  - busy=0, done=0, result=0, cb=0, ovf=0, zero=0.
  - An operation in progress is abandoned with no done pulse.
- Invalid parameters: a WIDTH that is not a multiple of DIGIT is a parameter error, flagged at elaboration.

## Timing
- Let start be sampled high at edge t.
  - busy is high for cycles t+1 … t+STEPS.
  - done is high for exactly one cycle, t+STEPS+1.
  - The result is valid from that same cycle.
- Latency: STEPS+1 cycles from the start edge to done, which is 5 cycles at the defaults.
- Back-to-back operation: start accepted in the DONE cycle begins a new operation with no IDLE gap, giving throughput of 1 op per STEPS+1 cycles.
- Inputs a, b and mode may change freely after the start edge.
- All outputs are registered; no output has a combinational path from any input.

## Structure
- Package addsub_pkg holds:
  - state encoding (IDLE, RUN, DONE, 2-bit);
  - MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- Sub-module digit_adder is combinational:
  - parameter DIGIT;
  - inputs x[DIGIT-1:0], y[DIGIT-1:0], ci;
  - outputs s[DIGIT-1:0], co, and c_msb (the carry into bit DIGIT-1).
  - It is instantiated once.
- Top level holds the FSM, the step counter ($clog2(STEPS) bits, minimum 1), the operand shift registers, the result register and the flag registers.

## Test plan
All scenarios use the defaults (WIDTH=16, DIGIT=4).
- sub 200-100 → result=100, cb=0, ovf=0, zero=0; done exactly 5 cycles after start; busy high for 4 cycles.
- sub 100-200 → result=16'hFF9C, cb=1, ovf=0.
- add 16'h7FFF+16'h0001 → result=16'h8000, cb=0, ovf=1.
- sub 16'h8000-16'h0001 → result=16'h7FFF, cb=0, ovf=1.
- add 16'hFFFF+16'h0001 → result=0, cb=1, zero=1, ovf=0.
- Handshake and reset:
  - start re-pulsed mid-RUN with new operands → ignored; the original result is produced.
  - start in the DONE cycle → the second result follows 5 cycles later.
  - rst asserted in the 2nd RUN cycle → next cycle busy=0, all outputs 0, and no done pulse.
